// File: rtl/mem_extreme_scan.sv
// Memory-block extreme finder: scans count words from base_addr and reports the
// max/min (signed or unsigned) and its index, with optional write-back.
module mem_extreme_scan #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int CNT_W  = 16,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              mode_min,
  input  logic              mode_signed,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  count,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic [CNT_W-1:0]  result_idx,
  output logic              empty_err
);

  localparam int DRW = 3;

  typedef enum logic [2:0] {S_IDLE, S_SCAN, S_DRAIN, S_WRITE, S_DONE} state_t;

  state_t              state_q, state_d;
  logic                min_q, sgn_q, wben_q;
  logic [ADDR_W-1:0]   base_q, wbaddr_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [CNT_W-1:0]    rd_idx_q, rd_idx_d;
  logic [DRW-1:0]      drain_q, drain_d;
  logic [RD_LAT-1:0]   vld_q;
  logic [CNT_W-1:0]    tag_q [RD_LAT];
  logic [DATA_W-1:0]   run_val_q, run_val_d;
  logic [CNT_W-1:0]    run_idx_q, run_idx_d;
  logic                have_q, have_d;
  logic [DATA_W-1:0]   result_q, result_d;
  logic [CNT_W-1:0]    result_idx_q, result_idx_d;
  logic                empty_q, empty_d;
  logic                accept, tap_vld, gt, lt, take;

  assign accept  = (state_q == S_IDLE) && start;
  assign tap_vld = vld_q[RD_LAT-1];
  assign gt = sgn_q ? ($signed(mem_rdata) > $signed(run_val_q)) : (mem_rdata > run_val_q);
  assign lt = sgn_q ? ($signed(mem_rdata) < $signed(run_val_q)) : (mem_rdata < run_val_q);
  // Strict compare so equal values never displace an earlier index.
  assign take = tap_vld && (!have_q || (min_q ? lt : gt));

  always_comb begin
    run_val_d = take ? mem_rdata : run_val_q;
    run_idx_d = take ? tag_q[RD_LAT-1] : run_idx_q;
    have_d    = (state_q == S_IDLE) ? 1'b0 : (have_q | tap_vld);
  end

  always_comb begin
    state_d      = state_q;
    rd_idx_d     = rd_idx_q;
    drain_d      = drain_q;
    result_d     = result_q;
    result_idx_d = result_idx_q;
    empty_d      = empty_q;
    mem_addr     = '0;
    mem_rd       = 1'b0;
    mem_wr       = 1'b0;
    mem_wdata    = '0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (count == '0) begin
            state_d      = S_DONE;
            result_d     = '0;
            result_idx_d = '0;
            empty_d      = 1'b1;
          end else begin
            state_d  = S_SCAN;
            rd_idx_d = '0;
          end
        end
      end
      S_SCAN: begin
        mem_rd   = 1'b1;
        mem_addr = base_q + ADDR_W'(rd_idx_q);
        if (rd_idx_q == cnt_q - CNT_W'(1)) begin
          state_d = S_DRAIN;
          drain_d = '0;
        end else begin
          rd_idx_d = rd_idx_q + CNT_W'(1);
        end
      end
      S_DRAIN: begin
        if (drain_q == DRW'(RD_LAT - 1)) begin
          if (wben_q) begin
            state_d = S_WRITE;
          end else begin
            state_d      = S_DONE;
            result_d     = run_val_d;
            result_idx_d = run_idx_d;
            empty_d      = 1'b0;
          end
        end else begin
          drain_d = drain_q + DRW'(1);
        end
      end
      S_WRITE: begin
        mem_wr       = 1'b1;
        mem_addr     = wbaddr_q;
        mem_wdata    = run_val_q;
        state_d      = S_DONE;
        result_d     = run_val_q;
        result_idx_d = run_idx_q;
        empty_d      = 1'b0;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      min_q        <= 1'b0;
      sgn_q        <= 1'b0;
      wben_q       <= 1'b0;
      base_q       <= '0;
      wbaddr_q     <= '0;
      cnt_q        <= '0;
      rd_idx_q     <= '0;
      drain_q      <= '0;
      vld_q        <= '0;
      for (int unsigned k = 0; k < RD_LAT; k++) tag_q[k] <= '0;
      run_val_q    <= '0;
      run_idx_q    <= '0;
      have_q       <= 1'b0;
      result_q     <= '0;
      result_idx_q <= '0;
      empty_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      rd_idx_q     <= rd_idx_d;
      drain_q      <= drain_d;
      run_val_q    <= run_val_d;
      run_idx_q    <= run_idx_d;
      have_q       <= have_d;
      result_q     <= result_d;
      result_idx_q <= result_idx_d;
      empty_q      <= empty_d;
      vld_q[0]     <= mem_rd;
      tag_q[0]     <= rd_idx_q;
      for (int unsigned k = 1; k < RD_LAT; k++) begin
        vld_q[k] <= vld_q[k-1];
        tag_q[k] <= tag_q[k-1];
      end
      if (accept) begin
        min_q    <= mode_min;
        sgn_q    <= mode_signed;
        wben_q   <= wb_en;
        base_q   <= base_addr;
        wbaddr_q <= wb_addr;
        cnt_q    <= count;
      end
    end
  end

  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);
  assign result     = result_q;
  assign result_idx = result_idx_q;
  assign empty_err  = empty_q;

endmodule

// File: tb/tb_mem_extreme_scan.sv
// Bench for mem_extreme_scan: two instances (read latency 1 and 3) against a
// behavioural memory and a loop-based reference of the scan result and timing.
module tb_mem_extreme_scan;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start0, start1, mode_min, mode_signed, wb_en;
  logic [15:0] base_addr, count, wb_addr;
  logic [15:0] maddr [2], wdata [2], res [2], ridx [2];
  logic        mrd [2], mwr [2], busy [2], done [2], emp [2];
  logic [15:0] rdata0, p1 [3];

  mem_extreme_scan #(.DATA_W(16), .ADDR_W(16), .CNT_W(16), .RD_LAT(1)) u0 (
    .clk(clk), .reset(reset), .start(start0), .mode_min(mode_min),
    .mode_signed(mode_signed), .base_addr(base_addr), .count(count),
    .wb_en(wb_en), .wb_addr(wb_addr), .mem_addr(maddr[0]), .mem_rd(mrd[0]),
    .mem_rdata(rdata0), .mem_wr(mwr[0]), .mem_wdata(wdata[0]), .busy(busy[0]),
    .done(done[0]), .result(res[0]), .result_idx(ridx[0]), .empty_err(emp[0]));

  mem_extreme_scan #(.DATA_W(16), .ADDR_W(16), .CNT_W(16), .RD_LAT(3)) u1 (
    .clk(clk), .reset(reset), .start(start1), .mode_min(mode_min),
    .mode_signed(mode_signed), .base_addr(base_addr), .count(count),
    .wb_en(wb_en), .wb_addr(wb_addr), .mem_addr(maddr[1]), .mem_rd(mrd[1]),
    .mem_rdata(p1[2]), .mem_wr(mwr[1]), .mem_wdata(wdata[1]), .busy(busy[1]),
    .done(done[1]), .result(res[1]), .result_idx(ridx[1]), .empty_err(emp[1]));

  // Memory contents are written only by the stimulus thread; write-backs are
  // observed on the port. Unrequested read slots return noise.
  logic [15:0] mem [0:65535];
  always @(posedge clk) begin
    rdata0 <= mrd[0] ? mem[maddr[0]] : 16'($urandom);
    p1[0]  <= mrd[1] ? mem[maddr[1]] : 16'($urandom);
    p1[1]  <= p1[0];
    p1[2]  <= p1[1];
  end

  int          nchk = 0, nfail = 0;
  int          k, sel, n, lat, td, nwr;
  bit          op_on, owb, ee;
  logic [15:0] ob, owba, ev, ei, last_wa, last_wd;
  logic [15:0] pv [2], pi [2];
  bit          pe [2];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: actual %0h required %0h (k=%0d sel=%0d)", nm, act, exp, k, sel);
    end
  endtask

  task automatic model(input int nn, input logic [15:0] b, input bit mn, input bit sg,
                       output logic [15:0] v, output logic [15:0] ix);
    logic [15:0] d;
    bit          better;
    v = 16'h0; ix = 16'h0;
    for (int i = 0; i < nn; i++) begin
      d = mem[16'(b + 16'(i))];
      if (sg) better = mn ? ($signed(d) < $signed(v)) : ($signed(d) > $signed(v));
      else    better = mn ? (d < v) : (d > v);
      if (i == 0 || better) begin v = d; ix = 16'(i); end
    end
  endtask

  always @(negedge clk) begin : cmp
    logic erd, ewr;
    logic [15:0] ea;
    if (op_on) begin
      erd = (n != 0) && k >= 1 && k <= n;
      ewr = (n != 0) && owb && k == n + lat + 1;
      ea  = erd ? 16'(ob + 16'(k - 1)) : (ewr ? owba : 16'h0);
      chk("busy", busy[sel], k >= 1 && k <= td);
      chk("done", done[sel], k == td);
      chk("mem_rd", mrd[sel], erd);
      chk("mem_wr", mwr[sel], ewr);
      chk("mem_addr", maddr[sel], ea);
      chk("mem_wdata", wdata[sel], ewr ? ev : 16'h0);
      chk("result", res[sel], k >= td ? ev : pv[sel]);
      chk("result_idx", ridx[sel], k >= td ? ei : pi[sel]);
      chk("empty_err", emp[sel], k >= td ? ee : pe[sel]);
      if (mwr[sel]) begin last_wa = maddr[sel]; last_wd = wdata[sel]; nwr++; end
    end
  end

  task automatic run_op(input int s, input int nn, input logic [15:0] b, input bit mn,
                        input bit sg, input bit wbe, input logic [15:0] wa);
    logic [15:0] v, ix;
    model(nn, b, mn, sg, v, ix);
    @(posedge clk); #2;
    sel = s; n = nn; lat = s ? 3 : 1; ob = b; owb = wbe; owba = wa;
    ev = v; ei = ix; ee = (nn == 0);
    td = (nn == 0) ? 1 : nn + lat + 1 + (wbe ? 1 : 0);
    base_addr = b; count = 16'(nn); mode_min = mn; mode_signed = sg;
    wb_en = wbe; wb_addr = wa;
    if (s != 0) start1 = 1'b1; else start0 = 1'b1;
    k = 0; op_on = 1'b1;
    for (int c = 1; c <= td + 2; c++) begin
      @(posedge clk); #2;
      k = c; start0 = 1'b0; start1 = 1'b0;
      // Busy and done-cycle starts carry junk configuration and must be ignored.
      if (c <= td && $urandom_range(0, 2) == 0) begin
        base_addr = 16'($urandom); count = 16'($urandom); wb_addr = 16'($urandom);
        mode_min = 1'($urandom); mode_signed = 1'($urandom); wb_en = 1'($urandom);
        if (s != 0) start1 = 1'b1; else start0 = 1'b1;
      end
    end
    op_on = 1'b0;
    pv[s] = ev; pi[s] = ei; pe[s] = ee;
  endtask

  task automatic chk_zero(input int s, input string tag);
    chk({tag, "_busy"}, busy[s], 0);   chk({tag, "_done"}, done[s], 0);
    chk({tag, "_rd"}, mrd[s], 0);      chk({tag, "_wr"}, mwr[s], 0);
    chk({tag, "_addr"}, maddr[s], 0);  chk({tag, "_wdata"}, wdata[s], 0);
    chk({tag, "_res"}, res[s], 0);     chk({tag, "_idx"}, ridx[s], 0);
    chk({tag, "_emp"}, emp[s], 0);
  endtask

  initial begin
    logic [15:0] t1 [8];
    int w0;
    t1 = '{16'd3, 16'd9, 16'd2, 16'd9, 16'd0, 16'd7, 16'd1, 16'd4};
    op_on = 1'b0; nwr = 0; k = 0; sel = 0;
    reset = 1'b1; start0 = 1'b0; start1 = 1'b0; mode_min = 1'b0; mode_signed = 1'b0;
    wb_en = 1'b0; base_addr = '0; count = '0; wb_addr = '0;
    for (int i = 0; i < 2; i++) begin pv[i] = '0; pi[i] = '0; pe[i] = 1'b0; end
    #1;
    chk_zero(0, "rst0"); chk_zero(1, "rst1");
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;

    // Unsigned max with a tie: first 9 wins.
    for (int i = 0; i < 8; i++) mem[16'h10 + i] = t1[i];
    run_op(0, 8, 16'h10, 0, 0, 0, 16'h0);
    chk("t1_model_val", ev, 16'd9); chk("t1_model_idx", ei, 16'd1);
    chk("t1_td", td, 10);           chk("t1_res", res[0], 16'd9);

    // Signed min with write-back, then unsigned min over the same words.
    mem[16'h10] = 16'h0005; mem[16'h11] = 16'hFFFE;
    mem[16'h12] = 16'h8000; mem[16'h13] = 16'h7FFF;
    w0 = nwr;
    run_op(0, 4, 16'h10, 1, 1, 1, 16'h40);
    chk("t2_model_val", ev, 16'h8000); chk("t2_model_idx", ei, 16'd2);
    chk("t2_nwr", nwr - w0, 1);
    chk("t2_wa", last_wa, 16'h40);     chk("t2_wd", last_wd, 16'h8000);
    run_op(0, 4, 16'h10, 1, 0, 0, 16'h0);
    chk("t2u_model_val", ev, 16'h0005); chk("t2u_model_idx", ei, 16'd0);

    // Zero count with write-back requested: no memory traffic at all.
    w0 = nwr;
    run_op(0, 0, 16'h10, 0, 0, 1, 16'h40);
    chk("t3_td", td, 1); chk("t3_emp", emp[0], 1); chk("t3_nwr", nwr - w0, 0);

    // Address wrap at read latency 3.
    mem[16'hFFFE] = 16'd1; mem[16'hFFFF] = 16'd2; mem[16'h0000] = 16'hA; mem[16'h0001] = 16'd3;
    run_op(1, 4, 16'hFFFE, 0, 0, 0, 16'h0);
    chk("t4_model_val", ev, 16'hA); chk("t4_model_idx", ei, 16'd2);
    chk("t4_td", td, 8);            chk("t4_res", res[1], 16'hA);

    // Reset during the third read cycle.
    for (int i = 0; i < 8; i++) mem[16'h200 + i] = 16'(i * 3 + 1);
    @(posedge clk); #2;
    base_addr = 16'h200; count = 16'd6; mode_min = 1'b0; mode_signed = 1'b0; wb_en = 1'b1;
    start0 = 1'b1;
    @(posedge clk); #2; start0 = 1'b0;
    @(posedge clk); #2;
    @(posedge clk); #2;
    chk("pre_rst_rd", mrd[0], 1); chk("pre_rst_addr", maddr[0], 16'h202);
    reset = 1'b1; #1;
    chk_zero(0, "midrst");
    for (int i = 0; i < 3; i++) begin @(negedge clk); chk("rst_nodone", done[0], 0); end
    #2 reset = 1'b0;
    for (int i = 0; i < 2; i++) begin pv[i] = '0; pi[i] = '0; pe[i] = 1'b0; end
    run_op(0, 2, 16'h200, 0, 0, 0, 16'h0);
    chk("t5_res", res[0], 16'd4); chk("t5_idx", ridx[0], 16'd1);

    // Randomised operations on both latencies.
    for (int t = 0; t < 40; t++) begin
      logic [15:0] b;
      int nn;
      b  = ($urandom_range(0, 3) == 0) ? 16'(16'hFFF0 + $urandom_range(0, 15)) : 16'($urandom);
      nn = $urandom_range(0, 20);
      for (int i = 0; i < nn; i++)
        mem[16'(b + 16'(i))] = t[0] ? 16'($urandom_range(0, 5) * 16'h3FFF) : 16'($urandom);
      run_op($urandom_range(0, 1), nn, b, 1'($urandom), 1'($urandom), 1'($urandom),
             16'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
